// File: rtl/jpeg_feed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_feed_pkg
// Description : Shared state encoding and timing constants for the JPEG
//               byte-feed controller.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_feed_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } feed_state_e;

    // Cycles spent swallowing late reader bytes after EOI
    localparam int FLUSH_CYCLES = 4;
    // Reader needs this many free entries of slack after pause is raised
    localparam int PAUSE_MARGIN = 3;

endpackage : jpeg_feed_pkg
`default_nettype wire

// File: rtl/jpeg_feed_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : feed_fifo
// Description : Synchronous register-array FIFO with registered read data and
//               a free-entry count. Pointers carry one wrap bit.
// Revision    : 1.0 - initial release
// ============================================================================
module feed_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_srst,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_free
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem_q [DEPTH];
    logic [AW:0]   r_wr_q;
    logic [AW:0]   r_rd_q;
    logic [DW-1:0] r_dout_q;
    logic [AW:0]   w_count;

    // Occupancy is the modular pointer difference; the wrap bit separates full from empty
    assign w_count = r_wr_q - r_rd_q;
    assign o_empty = (w_count == '0);
    assign o_full  = (w_count == C_DEPTH);
    assign o_free  = C_DEPTH - w_count;
    assign o_dout  = r_dout_q;

    // Pointer update; clear drops all stored content at once
    always_ff @(posedge i_clk) begin
        if (i_srst || i_clear) begin
            r_wr_q <= '0;
            r_rd_q <= '0;
        end else begin
            if (i_push) r_wr_q <= r_wr_q + 1'b1;
            if (i_pop)  r_rd_q <= r_rd_q + 1'b1;
        end
    end

    // Storage array write (no reset needed, occupancy is tracked by pointers)
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem_q[r_wr_q[AW-1:0]] <= i_din;
        end
    end

    // Registered read port so the byte lands one cycle after its pop
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_dout_q <= '0;
        end else if (i_pop && !i_clear) begin
            r_dout_q <= r_mem_q[r_rd_q[AW-1:0]];
        end
    end

endmodule : feed_fifo
`default_nettype wire

// File: rtl/jpeg_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_feed_ctrl
// Description : Requests one image from the flash reader, buffers its bytes
//               and forwards them to the JFIF parser until EOI, overflow or
//               runaway length.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_feed_ctrl
    import jpeg_feed_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int SLOT_W     = 4,
    parameter int SLOT_SHIFT = 16,
    parameter int FIFO_AW    = 4,
    parameter int LEN_W      = 20
) (
    input  logic              i_sysclk,
    input  logic              i_srst,
    input  logic              i_start,
    input  logic [SLOT_W-1:0] i_slot,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [7:0]        i_rd_byte,
    output logic              o_rd_pause,
    output logic              o_rd_stop,
    output logic              o_byte_en,
    output logic [7:0]        o_byte,
    input  logic              i_jfif_ready,
    input  logic              i_jfif_eoi
);

    localparam int FW = FIFO_AW + 1;
    localparam logic [LEN_W-1:0] C_LEN_MAX   = '1;
    localparam logic [FW-1:0]    C_PAUSE_LVL = FW'(PAUSE_MARGIN);
    localparam logic [2:0]       C_FLUSH_END = 3'(FLUSH_CYCLES - 1);

    feed_state_e       r_state_q, w_state_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [LEN_W-1:0]  r_len_q,   w_len_d;
    logic [2:0]        r_flush_q, w_flush_d;
    logic              r_byte_en_q;

    logic              w_push;
    logic              w_pop;
    logic              w_clear;
    logic              w_empty;
    logic              w_full;
    logic [FW-1:0]     w_free;
    logic [7:0]        w_dout;

    // The FIFO only holds data while streaming; every other state empties it
    assign w_clear = (r_state_q != ST_STREAM);

    feed_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_sysclk),
        .i_srst  (i_srst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_din   (i_rd_byte),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_free  (w_free)
    );

    // Next-state, FIFO handshake and counter logic
    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_len_d   = r_len_q;
        w_flush_d = r_flush_q;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        unique case (r_state_q)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_d = ST_REQ;
                    w_addr_d  = ADDR_W'(i_slot) << SLOT_SHIFT;
                    w_len_d   = '0;
                end
            end
            ST_REQ: begin
                w_flush_d = '0;
                if (i_rd_ack) w_state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // No pop on the EOI cycle so the parser strobe stops right away
                w_pop  = !w_empty && i_jfif_ready && !i_jfif_eoi;
                // A full FIFO still accepts a byte when a slot frees up this cycle
                w_push = i_rd_valid && (!w_full || w_pop);
                if (w_pop) w_len_d = r_len_q + 1'b1;
                if (i_jfif_eoi) begin
                    w_state_d = ST_FLUSH;
                    w_flush_d = '0;
                end else if (i_rd_valid && w_full && !w_pop) begin
                    w_state_d = ST_ERR;
                end else if (w_pop && (w_len_d == C_LEN_MAX)) begin
                    w_state_d = ST_ERR;
                end
            end
            ST_FLUSH: begin
                if (r_flush_q == C_FLUSH_END) w_state_d = ST_DONE;
                else                          w_flush_d = r_flush_q + 1'b1;
            end
            ST_DONE:  w_state_d = ST_IDLE;
            ST_ERR:   w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            r_state_q   <= ST_IDLE;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_flush_q   <= '0;
            r_byte_en_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_addr_q    <= w_addr_d;
            r_len_q     <= w_len_d;
            r_flush_q   <= w_flush_d;
            r_byte_en_q <= w_pop;
        end
    end

    assign o_busy     = (r_state_q != ST_IDLE);
    assign o_done     = (r_state_q == ST_DONE);
    assign o_err      = (r_state_q == ST_ERR);
    assign o_rd_req   = (r_state_q == ST_REQ);
    assign o_rd_addr  = (r_state_q == ST_REQ) ? r_addr_q : '0;
    assign o_rd_pause = (r_state_q == ST_STREAM) && (w_free <= C_PAUSE_LVL);
    assign o_rd_stop  = (r_state_q == ST_ERR) ||
                        ((r_state_q == ST_FLUSH) && (r_flush_q == '0));
    assign o_byte_en  = r_byte_en_q;
    assign o_byte     = w_dout;

endmodule : jpeg_feed_ctrl
`default_nettype wire
